// File: rtl/psum_accumulator.sv
// psum_accumulator: sums n products per partial sum into a 2-entry output FIFO,
// then flushes any residual group and drains to a sticky done state at end of stream.
module psum_accumulator #(
  parameter int DATA_WIDTH = 16,
  parameter int N_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  valid_mult,
  input  logic                  done_final,
  input  logic [DATA_WIDTH-1:0] MultOutReg,
  input  logic [N_WIDTH-1:0]    n,
  input  logic                  psum_ready,
  output logic                  stall,
  output logic                  psum_valid,
  output logic [DATA_WIDTH-1:0] psum_out,
  output logic                  done_out
);
  localparam logic [1:0] ACCUM = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] push_data;
  logic [N_WIDTH-1:0]    cnt;
  logic [N_WIDTH-1:0]    n_eff;
  logic [DATA_WIDTH-1:0] mem [2];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            count;
  logic                  accept_p;
  logic                  accept_d;
  logic                  last;
  logic                  push;
  logic                  pop;

  assign stall      = (count == 2'd2) || (state != ACCUM);
  assign accept_p   = valid_mult & ~stall;
  assign accept_d   = done_final & ~stall;
  assign n_eff      = (n == '0) ? N_WIDTH'(1) : n;
  assign last       = (cnt == n_eff - N_WIDTH'(1));
  assign sum        = acc + MultOutReg;
  // A residual push on end-of-stream also covers a group that completes that same cycle.
  assign push       = (accept_p & last) | (accept_d & (accept_p | (cnt != '0)));
  assign push_data  = accept_p ? sum : acc;
  assign psum_valid = (count != 2'd0);
  assign psum_out   = psum_valid ? mem[rd_ptr] : '0;
  assign pop        = psum_valid & psum_ready;
  assign done_out   = (state == DONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= ACCUM;
      acc    <= '0;
      cnt    <= '0;
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
      if (accept_d || (accept_p && last)) begin
        acc <= '0;
        cnt <= '0;
      end else if (accept_p) begin
        acc <= sum;
        cnt <= cnt + N_WIDTH'(1);
      end
      state <= (state == ACCUM && accept_d)       ? DRAIN :
               (state == DRAIN && count == 2'd0) ? DONE  : state;
    end
  end
endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator: directed scenarios with a queue scoreboard checked by an independent monitor.
module tb_psum_accumulator;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        valid_mult = 1'b0;
  logic        done_final = 1'b0;
  logic [15:0] MultOutReg = '0;
  logic [7:0]  n = 8'd1;
  logic        psum_ready = 1'b0;
  logic        stall;
  logic        psum_valid;
  logic [15:0] psum_out;
  logic        done_out;

  int total = 0;
  int bad = 0;
  logic [15:0] exp_q [$];

  psum_accumulator #(.DATA_WIDTH(16), .N_WIDTH(8)) dut (
    .clk(clk), .rstn(rstn), .valid_mult(valid_mult), .done_final(done_final),
    .MultOutReg(MultOutReg), .n(n), .psum_ready(psum_ready), .stall(stall),
    .psum_valid(psum_valid), .psum_out(psum_out), .done_out(done_out)
  );

  always #5 clk = ~clk;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rstn && psum_valid && psum_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL psum_extra: got %0h, expected no output", psum_out);
        end else begin
          if (psum_out !== exp_q[0]) begin
            bad++;
            $display("FAIL psum_out: got %0h, expected %0h", psum_out, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic [7:0] nv, input logic rdy);
    rstn = 1'b0;
    valid_mult = 1'b0;
    done_final = 1'b0;
    n = nv;
    psum_ready = rdy;
    exp_q.delete();
    step();
    step();
    rstn = 1'b1;
    step();
  endtask

  task automatic send(input logic [15:0] p, input logic d);
    int k;
    valid_mult = 1'b1;
    MultOutReg = p;
    done_final = d;
    k = 0;
    while (stall && k < 50) begin
      step();
      k++;
    end
    if (k == 50) chk("send_timeout", 32'(stall), 32'd0);
    step();
    valid_mult = 1'b0;
    done_final = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || psum_valid) && k < 50) begin
      step();
      k++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done_out && k < 50) begin
      step();
      k++;
    end
    chk("done_out", 32'(done_out), 32'd1);
  endtask

  initial begin
    do_reset(8'd3, 1'b1);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_valid", 32'(psum_valid), 32'd0);
    chk("rst_out", 32'(psum_out), 32'd0);
    chk("rst_done", 32'(done_out), 32'd0);

    exp_q.push_back(16'd9);
    send(16'd2, 1'b0);
    send(16'd3, 1'b0);
    chk("basic_early", 32'(psum_valid), 32'd0);
    send(16'd4, 1'b0);
    chk("basic_latency", 32'(psum_valid), 32'd1);
    step();
    chk("basic_one_cycle", 32'(psum_valid), 32'd0);
    drain();

    do_reset(8'd2, 1'b1);
    exp_q.push_back(16'h8000);
    exp_q.push_back(16'hFFFE);
    send(16'h7FFF, 1'b0);
    send(16'h0001, 1'b0);
    send(16'hFFFF, 1'b0);
    send(16'hFFFF, 1'b0);
    drain();

    do_reset(8'd0, 1'b1);
    exp_q.push_back(16'd7);
    exp_q.push_back(16'd8);
    send(16'd7, 1'b0);
    send(16'd8, 1'b0);
    drain();

    do_reset(8'd1, 1'b0);
    exp_q.push_back(16'd1);
    exp_q.push_back(16'd2);
    exp_q.push_back(16'd3);
    send(16'd1, 1'b0);
    send(16'd2, 1'b0);
    chk("bp_stall", 32'(stall), 32'd1);
    valid_mult = 1'b1;
    MultOutReg = 16'd3;
    step();
    step();
    chk("bp_held_stall", 32'(stall), 32'd1);
    chk("bp_head", 32'(psum_out), 32'd1);
    psum_ready = 1'b1;
    send(16'd3, 1'b0);
    drain();

    do_reset(8'd4, 1'b1);
    exp_q.push_back(16'd11);
    send(16'd5, 1'b0);
    send(16'd6, 1'b0);
    done_final = 1'b1;
    step();
    done_final = 1'b0;
    chk("flush_stall", 32'(stall), 32'd1);
    chk("flush_done_early", 32'(done_out), 32'd0);
    wait_done();
    valid_mult = 1'b1;
    MultOutReg = 16'd9;
    step();
    step();
    valid_mult = 1'b0;
    chk("flush_done_sticky", 32'(done_out), 32'd1);
    chk("flush_stall_done", 32'(stall), 32'd1);
    chk("flush_left", 32'(exp_q.size()), 32'd0);

    do_reset(8'd2, 1'b1);
    exp_q.push_back(16'd3);
    send(16'd1, 1'b0);
    send(16'd2, 1'b1);
    wait_done();
    step();
    step();
    chk("simul_left", 32'(exp_q.size()), 32'd0);

    do_reset(8'd3, 1'b0);
    send(16'd1, 1'b0);
    send(16'd1, 1'b0);
    send(16'd1, 1'b0);
    send(16'd5, 1'b0);
    chk("mid_queued", 32'(psum_valid), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(psum_valid), 32'd0);
    chk("mid_rst_out", 32'(psum_out), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_done", 32'(done_out), 32'd0);
    step();
    rstn = 1'b1;
    psum_ready = 1'b1;
    step();
    exp_q.push_back(16'd3);
    send(16'd1, 1'b0);
    send(16'd1, 1'b0);
    send(16'd1, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
